// File: rtl/uart_pkg.sv
// uart_pkg: constants and helpers shared by the baud generator and the
// UART TX/RX engines.
//   MIN_DIV          smallest legal divisor (clocks per RX oversample tick)
//   DEF_*            default clock / baud / oversample settings
//   calc_default_div reset divisor = max(MIN_DIV, clk/(baud*oversample))
package uart_pkg;

  localparam int MIN_DIV        = 2;
  localparam int DEF_CLK_HZ     = 50_000_000;
  localparam int DEF_BAUD       = 115_200;
  localparam int DEF_OVERSAMPLE = 16;
  localparam int DEF_DIV_W      = 16;

  function automatic int calc_default_div(input int clk_hz, input int baud,
                                          input int oversample);
    int q;
    q = clk_hz / (baud * oversample);
    return (q < MIN_DIV) ? MIN_DIV : q;
  endfunction

endpackage

// File: rtl/tick_counter.sv
// tick_counter: modulo-N counter with runtime terminal value.
//   clock, reset  rising-edge clock, async active-high reset
//   i_en          count enable (hold when low)
//   i_clr         synchronous clear, wins over counting
//   i_last        terminal value (N-1)
//   o_cnt         current count
//   o_term        combinational wrap strobe: enabled, not clearing, at terminal
module tick_counter
  import uart_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         i_en,
  input  logic         i_clr,
  input  logic [W-1:0] i_last,
  output logic [W-1:0] o_cnt,
  output logic         o_term
);

  logic [W-1:0] r_cnt;

  // ">=" keeps the counter bounded if the terminal value shrinks below the
  // current count while counting is frozen.
  assign o_term = i_en && !i_clr && (r_cnt >= i_last);
  assign o_cnt  = r_cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_clr || o_term) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: baud / oversample tick generator shared by UART TX and RX.
//   clock, reset  rising-edge clock, async active-high reset
//   enable        count enable; low freezes counters and slow_clock
//   div_load      one-cycle request to load div_value
//   div_value     new divisor (clocks per rx_tick), must be >= MIN_DIV
//   rx_sync       restart RX/TX phase (start-bit edge)
//   rx_tick       pulse every div clocks
//   rx_mid        pulse at the mid-bit sample point
//   tx_tick       pulse every div*OVERSAMPLE clocks
//   slow_clock    bit-rate square wave, 50% duty
//   div_pending   loaded divisor waiting to be applied
//   div_err       pulse: illegal divisor rejected
// All outputs are registered.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLK        = DEF_CLK_HZ,
  parameter int BAUD       = DEF_BAUD,
  parameter int OVERSAMPLE = DEF_OVERSAMPLE,
  parameter int DIV_W      = DEF_DIV_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             div_load,
  input  logic [DIV_W-1:0] div_value,
  input  logic             rx_sync,
  output logic             rx_tick,
  output logic             rx_mid,
  output logic             tx_tick,
  output logic             slow_clock,
  output logic             div_pending,
  output logic             div_err
);

  localparam int               OS_W        = $clog2(OVERSAMPLE);
  localparam int               DEFAULT_DIV = calc_default_div(CLK, BAUD, OVERSAMPLE);
  localparam logic [DIV_W-1:0] DEF_DIV     = DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W-1:0] MIN_DIV_V   = DIV_W'(MIN_DIV);
  localparam logic [OS_W-1:0]  OS_LAST     = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0]  OS_HALF_M1  = OS_W'(OVERSAMPLE / 2 - 1);

  logic [DIV_W-1:0] r_div_cur;
  logic [DIV_W-1:0] r_div_pend;
  logic             r_pending;
  logic             r_rx_tick;
  logic             r_rx_mid;
  logic             r_tx_tick;
  logic             r_slow;
  logic             r_err;

  logic [DIV_W-1:0] w_unused_rx_cnt;  // only the wrap strobe of this counter matters
  logic             w_rx_wrap;
  logic [OS_W-1:0]  w_os_cnt;
  logic             w_os_wrap;
  logic             w_mid;
  logic             w_load_ok;
  logic             w_load_bad;
  logic             w_apply_pend;

  tick_counter #(.W(DIV_W)) u_rx_cnt (
    .clock  (clock),
    .reset  (reset),
    .i_en   (enable),
    .i_clr  (rx_sync),
    .i_last (r_div_cur - 1'b1),
    .o_cnt  (w_unused_rx_cnt),
    .o_term (w_rx_wrap)
  );

  // Oversample counter advances once per RX wrap.
  tick_counter #(.W(OS_W)) u_os_cnt (
    .clock  (clock),
    .reset  (reset),
    .i_en   (w_rx_wrap),
    .i_clr  (rx_sync),
    .i_last (OS_LAST),
    .o_cnt  (w_os_cnt),
    .o_term (w_os_wrap)
  );

  assign w_mid        = w_rx_wrap && (w_os_cnt == OS_HALF_M1);
  assign w_load_ok    = div_load && (div_value >= MIN_DIV_V);
  assign w_load_bad   = div_load && (div_value <  MIN_DIV_V);
  // A frozen or resynchronised generator has no period in flight to protect.
  assign w_apply_pend = r_pending && (w_rx_wrap || !enable || rx_sync);

  // Output / control register stage
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_div_cur <= DEF_DIV;
      r_pending <= 1'b0;
      r_rx_tick <= 1'b0;
      r_rx_mid  <= 1'b0;
      r_tx_tick <= 1'b0;
      r_slow    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_rx_tick <= w_rx_wrap;
      r_rx_mid  <= w_mid;
      r_tx_tick <= w_os_wrap;
      r_err     <= w_load_bad;

      if (rx_sync || w_os_wrap) begin
        r_slow <= 1'b1;
      end else if (w_mid) begin
        r_slow <= 1'b0;
      end

      // A load landing on a wrap takes effect at that wrap directly.
      if (w_load_ok && w_rx_wrap) begin
        r_div_cur <= div_value;
        r_pending <= 1'b0;
      end else if (w_load_ok) begin
        r_pending <= 1'b1;
      end else if (w_apply_pend) begin
        r_div_cur <= r_div_pend;
        r_pending <= 1'b0;
      end
    end
  end

  // Pending divisor holds data only; its valid flag is r_pending.
  always_ff @(posedge clock) begin
    if (w_load_ok) begin
      r_div_pend <= div_value;
    end
  end

  assign rx_tick     = r_rx_tick;
  assign rx_mid      = r_rx_mid;
  assign tx_tick     = r_tx_tick;
  assign slow_clock  = r_slow;
  assign div_pending = r_pending;
  assign div_err     = r_err;

endmodule

// File: tb/tb_uart_baud_gen.sv
// Scoreboard bench for uart_baud_gen: stimulus pushes (cycle, signal, value)
// expectations; a negedge monitor pops and compares them.
module tb_uart_baud_gen;

  localparam int RXT = 0, MID = 1, TXT = 2, SLW = 3, PND = 4, ERR = 5, D4 = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, en, ld, sy;
  logic [15:0] dv;
  logic        rxt, mid, txt, slw, pnd, err;
  logic        rst4, en4, ld4, sy4;
  logic [15:0] dv4;
  logic        rxt4, mid4, txt4, slw4, pnd4, err4;

  uart_baud_gen dut (
    .clock(clk), .reset(rst), .enable(en), .div_load(ld), .div_value(dv),
    .rx_sync(sy), .rx_tick(rxt), .rx_mid(mid), .tx_tick(txt),
    .slow_clock(slw), .div_pending(pnd), .div_err(err)
  );

  uart_baud_gen #(.OVERSAMPLE(4)) dut4 (
    .clock(clk), .reset(rst4), .enable(en4), .div_load(ld4), .div_value(dv4),
    .rx_sync(sy4), .rx_tick(rxt4), .rx_mid(mid4), .tx_tick(txt4),
    .slow_clock(slw4), .div_pending(pnd4), .div_err(err4)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int   c;
    int   id;
    logic v;
  } exp_t;
  exp_t sb[$];

  string nm[12] = '{"rx_tick", "rx_mid", "tx_tick", "slow_clock", "div_pending", "div_err",
                    "rx_tick4", "rx_mid4", "tx_tick4", "slow_clock4", "div_pending4", "div_err4"};

  int total = 0;
  int bad   = 0;

  function automatic logic sig(input int id);
    case (id)
      0: return rxt;   1: return mid;   2: return txt;
      3: return slw;   4: return pnd;   5: return err;
      6: return rxt4;  7: return mid4;  8: return txt4;
      9: return slw4; 10: return pnd4; 11: return err4;
      default: return 1'bx;
    endcase
  endfunction

  task automatic check(input string name, input logic act, input logic want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %b, expected %b", name, act, want);
    end
  endtask

  task automatic push(input int c, input int id, input logic v);
    sb.push_back('{c, id, v});
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Monitor: compare every expectation due at this sample point.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].c == cyc) begin
        check($sformatf("%s@%0d", nm[sb[i].id], sb[i].c), sig(sb[i].id), sb[i].v);
        sb.delete(i);
      end else if (sb[i].c < cyc) begin
        total++;
        bad++;
        $display("FAIL %s@%0d: not sampled, expected %b", nm[sb[i].id], sb[i].c, sb[i].v);
        sb.delete(i);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  int k0, k, t, s, r, kb;

  initial begin
    rst = 1'b1; en = 1'b0; ld = 1'b0; dv = '0; sy = 1'b0;
    rst4 = 1'b1; en4 = 1'b0; ld4 = 1'b0; dv4 = '0; sy4 = 1'b0;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 12; i++) check({nm[i], "_reset"}, sig(i), 1'b0);

    // Defaults, OVERSAMPLE=16, div 27
    k0 = cyc;
    rst = 1'b0; en = 1'b1;
    push(k0 + 5, PND, 0);       push(k0 + 5, ERR, 0);
    push(k0 + 26, RXT, 0);      push(k0 + 27, RXT, 1);
    push(k0 + 28, RXT, 0);      push(k0 + 54, RXT, 1);
    push(k0 + 216, MID, 1);     push(k0 + 215, MID, 0);
    push(k0 + 431, TXT, 0);     push(k0 + 432, TXT, 1);   push(k0 + 433, TXT, 0);
    push(k0 + 431, SLW, 0);     push(k0 + 432, SLW, 1);
    push(k0 + 647, SLW, 1);     push(k0 + 648, SLW, 0);
    push(k0 + 647, MID, 0);     push(k0 + 648, MID, 1);
    push(k0 + 864, TXT, 1);     push(k0 + 864, SLW, 1);

    // Divisor 10 loaded mid-period
    k = k0 + 27 * 40 + 10;
    t = k0 + 27 * 41;
    wait_cyc(k);
    ld = 1'b1; dv = 16'd10;
    push(k + 1, PND, 1);  push(t - 1, PND, 1);  push(t, PND, 0);
    push(t - 1, RXT, 0);  push(t, RXT, 1);
    push(t + 9, RXT, 0);  push(t + 10, RXT, 1); push(t + 20, RXT, 1);
    @(negedge clk);
    ld = 1'b0;

    // Illegal divisors 1 then 0
    wait_cyc(t + 53);
    ld = 1'b1; dv = 16'd1;
    push(t + 54, ERR, 1); push(t + 54, PND, 0);
    push(t + 55, ERR, 1); push(t + 55, PND, 0);
    push(t + 56, ERR, 0);
    push(t + 59, RXT, 0); push(t + 60, RXT, 1); push(t + 70, RXT, 1);
    @(negedge clk);
    dv = 16'd0;
    @(negedge clk);
    ld = 1'b0;

    // rx_sync on the terminal-count edge
    s = t + 100;
    wait_cyc(s - 1);
    sy = 1'b1;
    push(s, RXT, 0);       push(s, SLW, 1);       push(s, TXT, 0);
    push(s + 9, RXT, 0);   push(s + 10, RXT, 1);
    push(s + 79, SLW, 1);  push(s + 80, SLW, 0);  push(s + 80, MID, 1);
    push(s + 159, TXT, 0); push(s + 160, TXT, 1); push(s + 160, SLW, 1);
    @(negedge clk);
    sy = 1'b0;

    // Enable low for 5 cycles mid-period
    wait_cyc(s + 203);
    en = 1'b0;
    for (int i = 204; i <= 210; i++) push(s + i, RXT, 0);
    push(s + 206, SLW, 1);
    push(s + 214, RXT, 0); push(s + 215, RXT, 1); push(s + 216, RXT, 0);
    push(s + 220, SLW, 1);
    wait_cyc(s + 208);
    en = 1'b1;

    // Asynchronous reset mid-period
    wait_cyc(s + 220);
    #2;
    rst = 1'b1;
    #1;
    for (int i = 0; i < 6; i++) check({nm[i], "_async_reset"}, sig(i), 1'b0);
    @(negedge clk);
    r = cyc;
    rst = 1'b0;
    push(r + 26, RXT, 0); push(r + 27, RXT, 1); push(r + 54, RXT, 1);

    // OVERSAMPLE=4, divisor 4 loaded while disabled
    wait_cyc(r + 60);
    kb = cyc;
    rst4 = 1'b0; ld4 = 1'b1; dv4 = 16'd4;
    push(kb + 1, D4 + PND, 1);  push(kb + 2, D4 + PND, 0);  push(kb + 3, D4 + PND, 0);
    push(kb + 5, D4 + RXT, 0);  push(kb + 6, D4 + RXT, 1);
    push(kb + 7, D4 + RXT, 0);  push(kb + 10, D4 + RXT, 1);
    push(kb + 6, D4 + MID, 0);  push(kb + 10, D4 + MID, 1);  push(kb + 26, D4 + MID, 1);
    push(kb + 14, D4 + TXT, 0); push(kb + 18, D4 + TXT, 1);  push(kb + 34, D4 + TXT, 1);
    push(kb + 17, D4 + SLW, 0); push(kb + 18, D4 + SLW, 1);
    push(kb + 25, D4 + SLW, 1); push(kb + 26, D4 + SLW, 0);
    @(negedge clk);
    ld4 = 1'b0;
    @(negedge clk);
    en4 = 1'b1;
    wait_cyc(kb + 40);

    @(negedge clk);
    foreach (sb[i]) begin
      total++;
      bad++;
      $display("FAIL %s@%0d: never checked, expected %b", nm[sb[i].id], sb[i].c, sb[i].v);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
